// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/sequencing controller in front of the shared ALU
// datapath. Accepts one operation at a time over a valid/ready request
// handshake, latches its operands, drives the ALU control strobes for a
// per-class number of EXEC cycles and returns completion over a valid/ready
// response. Divide-by-zero and illegal opcodes are rejected without loading
// the result register.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   req_valid/req_ready       request handshake
//   req_opcode, req_use_imm   operation code, B operand = imm select
//   req_op1/op2/imm           request operands
//   op1_q/op2_q/imm_q         latched operands to the ALU
//   isImmediate, is*          ALU B-mux select and one-hot op strobes
//   aluSel                    ALU result-mux select
//   ldResult, clrResult       result register load / clear
//   flag_wr                   flag register write strobe (CMP only)
//   rsp_valid/rsp_ready       response handshake, rsp_err = op rejected
//   busy                      an operation is executing or awaiting response
//
// Optional build macro ALU_SEQ_PERF_EN adds perf_ops / perf_stall counters.
module alu_sequencer #(
  parameter int unsigned MUL_CYCLES  = 2,
  parameter int unsigned DIV_CYCLES  = 8,
  parameter int unsigned BASE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_opcode,
  input  logic        req_use_imm,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  input  logic [31:0] req_imm,
  output logic [31:0] op1_q,
  output logic [31:0] op2_q,
  output logic [31:0] imm_q,
  output logic        isImmediate,
  output logic        isAdd,
  output logic        isSub,
  output logic        isCmp,
  output logic        isMul,
  output logic        isDiv,
  output logic        isMod,
  output logic        isLsl,
  output logic        isLsr,
  output logic        isAsr,
  output logic        isOr,
  output logic        isNot,
  output logic        isAnd,
  output logic        isMov,
  output logic [2:0]  aluSel,
  output logic        ldResult,
  output logic        clrResult,
  output logic        flag_wr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_err,
`ifdef ALU_SEQ_PERF_EN
  output logic [31:0] perf_ops,
  output logic [31:0] perf_stall,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC, S_RESP} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_CMP = 4'd2, OP_MUL = 4'd3,
    OP_DIV = 4'd4, OP_MOD = 4'd5, OP_LSL = 4'd6, OP_LSR = 4'd7,
    OP_ASR = 4'd8, OP_OR  = 4'd9, OP_NOT = 4'd10, OP_AND = 4'd11,
    OP_MOV = 4'd12
  } opcode_t;

  localparam logic [7:0] MUL_CNT  = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_CNT  = 8'(DIV_CYCLES - 1);
  localparam logic [7:0] BASE_CNT = 8'(BASE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [3:0]  opc_q;
  logic        use_imm_q;
  logic        err_q;
  logic        accept;
  logic        req_is_div;
  logic        reject;
  logic [31:0] eff_b;
  logic [7:0]  class_cnt;

  assign accept     = (state == S_IDLE) && req_valid;
  assign eff_b      = req_use_imm ? req_imm : req_op2;
  assign req_is_div = (req_opcode == OP_DIV) || (req_opcode == OP_MOD);
  // Only the effective B operand can cause a divide-by-zero reject.
  assign reject     = (req_opcode > OP_MOV) || (req_is_div && (eff_b == '0));
  assign class_cnt  = (req_opcode == OP_MUL) ? MUL_CNT :
                      req_is_div             ? DIV_CNT : BASE_CNT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      cnt       <= '0;
      opc_q     <= '0;
      use_imm_q <= 1'b0;
      err_q     <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      imm_q     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        opc_q     <= req_opcode;
        use_imm_q <= req_use_imm;
        err_q     <= reject;
        op1_q     <= req_op1;
        op2_q     <= req_op2;
        imm_q     <= req_imm;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_INIT: state_nxt = S_IDLE;
      S_IDLE: begin
        if (req_valid) begin
          if (reject) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_EXEC;
            cnt_nxt   = class_cnt;
          end
        end
      end
      S_EXEC: begin
        if (cnt == '0) state_nxt = S_RESP;
        else           cnt_nxt   = cnt - 8'd1;
      end
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    clrResult   = 1'b0;
    isImmediate = 1'b0;
    isAdd = 1'b0; isSub = 1'b0; isCmp = 1'b0; isMul = 1'b0;
    isDiv = 1'b0; isMod = 1'b0; isLsl = 1'b0; isLsr = 1'b0;
    isAsr = 1'b0; isOr  = 1'b0; isNot = 1'b0; isAnd = 1'b0;
    isMov = 1'b0;
    aluSel    = '0;
    ldResult  = 1'b0;
    flag_wr   = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    busy      = 1'b0;
    unique case (state)
      S_INIT: clrResult = 1'b1;
      S_IDLE: req_ready = 1'b1;
      S_EXEC: begin
        busy        = 1'b1;
        isImmediate = use_imm_q;
        // Final EXEC cycle commits the result (and flags for CMP).
        ldResult    = (cnt == '0);
        unique case (opc_q)
          OP_ADD: begin isAdd = 1'b1; aluSel = 3'd0; end
          OP_SUB: begin isSub = 1'b1; aluSel = 3'd0; end
          OP_CMP: begin isCmp = 1'b1; aluSel = 3'd0; flag_wr = (cnt == '0); end
          OP_MUL: begin isMul = 1'b1; aluSel = 3'd1; end
          OP_DIV: begin isDiv = 1'b1; aluSel = 3'd2; end
          OP_MOD: begin isMod = 1'b1; aluSel = 3'd2; end
          OP_MOV: begin isMov = 1'b1; aluSel = 3'd3; end
          OP_OR:  begin isOr  = 1'b1; aluSel = 3'd4; end
          OP_NOT: begin isNot = 1'b1; aluSel = 3'd4; end
          OP_AND: begin isAnd = 1'b1; aluSel = 3'd4; end
          OP_LSL: begin isLsl = 1'b1; aluSel = 3'd5; end
          OP_LSR: begin isLsr = 1'b1; aluSel = 3'd5; end
          OP_ASR: begin isAsr = 1'b1; aluSel = 3'd5; end
          default: ;
        endcase
      end
      S_RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      // Only the EXEC->RESP transition is a non-error entry to RESP.
      if (state == S_EXEC && cnt == '0) perf_ops <= perf_ops + 32'd1;
      if (state == S_RESP && !rsp_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam int unsigned MUL_N  = 2;
  localparam int unsigned DIV_N  = 8;
  localparam int unsigned BASE_N = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_opcode = '0;
  logic        req_use_imm = 1'b0;
  logic [31:0] req_op1 = '0, req_op2 = '0, req_imm = '0;
  logic [31:0] op1_q, op2_q, imm_q;
  logic        isImmediate;
  logic        isAdd, isSub, isCmp, isMul, isDiv, isMod, isLsl;
  logic        isLsr, isAsr, isOr, isNot, isAnd, isMov;
  logic [2:0]  aluSel;
  logic        ldResult, clrResult, flag_wr;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_err, busy;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_ops, perf_stall;
`endif

  alu_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .BASE_CYCLES(BASE_N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_use_imm(req_use_imm), .req_op1(req_op1),
    .req_op2(req_op2), .req_imm(req_imm), .op1_q(op1_q), .op2_q(op2_q),
    .imm_q(imm_q), .isImmediate(isImmediate), .isAdd(isAdd), .isSub(isSub),
    .isCmp(isCmp), .isMul(isMul), .isDiv(isDiv), .isMod(isMod), .isLsl(isLsl),
    .isLsr(isLsr), .isAsr(isAsr), .isOr(isOr), .isNot(isNot), .isAnd(isAnd),
    .isMov(isMov), .aluSel(aluSel), .ldResult(ldResult), .clrResult(clrResult),
    .flag_wr(flag_wr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_err(rsp_err),
`ifdef ALU_SEQ_PERF_EN
    .perf_ops(perf_ops), .perf_stall(perf_stall),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Strobe vector indexed by opcode number: bit k is the strobe for opcode k.
  logic [12:0] sv;
  assign sv = {isMov, isAnd, isNot, isOr, isAsr, isLsr, isLsl,
               isMod, isDiv, isMul, isCmp, isSub, isAdd};

  int checks = 0;
  int failures = 0;
  int exp_ops = 0;
  int exp_stall = 0;
  int sel_tab[13] = '{0, 0, 0, 1, 2, 2, 5, 5, 5, 4, 4, 4, 3};

  typedef struct {
    logic [3:0]  opc;
    logic        ui;
    logic [31:0] a, b, c;
    bit          err;
    int          sel;
    int          n;
    int          stall;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: derived directly from the opcode map and reject rules.
  function automatic bit m_err(input logic [3:0] opc, input logic ui,
                               input logic [31:0] b, input logic [31:0] c);
    logic [31:0] eff;
    eff = ui ? c : b;
    return (opc >= 13) || ((opc == 4 || opc == 5) && eff == 0);
  endfunction

  function automatic int m_cycles(input logic [3:0] opc);
    if (opc == 3) return MUL_N;
    if (opc == 4 || opc == 5) return DIV_N;
    return BASE_N;
  endfunction

  task automatic check_perf(input string nm);
`ifdef ALU_SEQ_PERF_EN
    chk({nm, "_perf_ops"}, 64'(perf_ops), 64'(exp_ops));
    chk({nm, "_perf_stall"}, 64'(perf_stall), 64'(exp_stall));
`else
    nm = nm;
`endif
  endtask

  // Called on a negedge with rst already asserted; returns on a negedge in IDLE.
  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_clr", 64'(clrResult), 64'd1);
    chk("init_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("idle_clr", 64'(clrResult), 64'd0);
    chk("idle_ready", 64'(req_ready), 64'd1);
    chk("idle_strobes", 64'(sv), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    exp_ops = 0;
    exp_stall = 0;
    check_perf("reset");
  endtask

  // Issues one op from IDLE (at a negedge) and checks it cycle by cycle.
  task automatic run_op(input logic [3:0] opc, input logic ui, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input bit e_err,
                        input int e_sel, input int e_n, input int stall);
    int n;
    n = e_err ? 0 : e_n;
    chk("pre_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_opcode = opc; req_use_imm = ui;
    req_op1 = a; req_op2 = b; req_imm = c;
    rsp_ready = (stall == 0);
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("exec_strobe", 64'(sv), 64'(13'd1 << opc));
      chk("exec_sel", 64'(aluSel), 64'(e_sel));
      chk("exec_imm", 64'(isImmediate), 64'(ui));
      chk("exec_ld", 64'(ldResult), 64'(k == n));
      chk("exec_flag", 64'(flag_wr), 64'(k == n && opc == 2));
      chk("exec_rsp", 64'(rsp_valid), 64'd0);
      chk("exec_ready", 64'(req_ready), 64'd0);
      chk("exec_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("op1_q", 64'(op1_q), 64'(a));
    chk("op2_q", 64'(op2_q), 64'(b));
    chk("imm_q", 64'(imm_q), 64'(c));
    chk("resp_valid", 64'(rsp_valid), 64'd1);
    chk("resp_err", 64'(rsp_err), 64'(e_err));
    chk("resp_strobes", 64'(sv), 64'd0);
    chk("resp_sel", 64'(aluSel), 64'd0);
    chk("resp_ld", 64'({ldResult, flag_wr}), 64'd0);
    chk("resp_ready", 64'(req_ready), 64'd0);
    if (!e_err) exp_ops++;
    for (int s = 0; s < stall; s++) begin
      if (s == 0) begin
        // A competing request must wait until the sequencer is back in IDLE.
        req_valid = 1'b1; req_opcode = 4'd0; req_op1 = ~a;
      end
      @(negedge clk);
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_ready", 64'(req_ready), 64'd0);
    end
    exp_stall += stall;
    check_perf("resp");
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("done_valid", 64'(rsp_valid), 64'd0);
    chk("done_ready", 64'(req_ready), 64'd1);
    chk("done_op1_hold", 64'(op1_q), 64'(a));
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ADD, DIV/imm=0 reject, DIV imm=7, CMP, MUL with stall, opcode 14, etc.
    tab.push_back('{4'd0,  1'b0, 32'd5,   32'd7, 32'd0,   1'b0, 0, 1, 0});
    tab.push_back('{4'd4,  1'b1, 32'd100, 32'd9, 32'd0,   1'b1, 2, 8, 0});
    tab.push_back('{4'd4,  1'b1, 32'd100, 32'd0, 32'd7,   1'b0, 2, 8, 0});
    tab.push_back('{4'd2,  1'b0, 32'd3,   32'd3, 32'd0,   1'b0, 0, 1, 0});
    tab.push_back('{4'd3,  1'b0, 32'd6,   32'd7, 32'd0,   1'b0, 1, 2, 5});
    tab.push_back('{4'd14, 1'b0, 32'd1,   32'd2, 32'd3,   1'b1, 0, 1, 0});
    tab.push_back('{4'd12, 1'b1, 32'd0,   32'd0, 32'h55,  1'b0, 3, 1, 0});
    tab.push_back('{4'd5,  1'b0, 32'd1,   32'd0, 32'd9,   1'b1, 2, 8, 0});
    tab.push_back('{4'd5,  1'b1, 32'd1,   32'd0, 32'd3,   1'b0, 2, 8, 1});
    tab.push_back('{4'd4,  1'b0, 32'd0,   32'd5, 32'd0,   1'b0, 2, 8, 0});
    tab.push_back('{4'd1,  1'b0, 32'd9,   32'd4, 32'd0,   1'b0, 0, 1, 0});
    tab.push_back('{4'd6,  1'b1, 32'd1,   32'd0, 32'd4,   1'b0, 5, 1, 0});
    tab.push_back('{4'd7,  1'b0, 32'hF0,  32'd4, 32'd0,   1'b0, 5, 1, 0});
    tab.push_back('{4'd8,  1'b0, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 5, 1, 2});
    tab.push_back('{4'd9,  1'b0, 32'h0F,  32'hF0, 32'd0,  1'b0, 4, 1, 0});
    tab.push_back('{4'd10, 1'b0, 32'h0F,  32'd0, 32'd0,   1'b0, 4, 1, 0});
    tab.push_back('{4'd11, 1'b1, 32'hFF,  32'd0, 32'h0F,  1'b0, 4, 1, 0});
    tab.push_back('{4'd13, 1'b0, 32'd1,   32'd1, 32'd1,   1'b1, 0, 1, 0});
    tab.push_back('{4'd15, 1'b1, 32'd1,   32'd1, 32'd1,   1'b1, 0, 1, 0});

    // Reset state while rst is held.
    @(negedge clk);
    chk("rst_clr", 64'(clrResult), 64'd1);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_strobes", 64'(sv), 64'd0);
    chk("rst_outs", 64'({ldResult, flag_wr, rsp_valid, rsp_err, isImmediate, aluSel}), 64'd0);
    chk("rst_ops", 64'({op1_q, op2_q} | 64'(imm_q)), 64'd0);
    release_reset();

    foreach (tab[i])
      run_op(tab[i].opc, tab[i].ui, tab[i].a, tab[i].b, tab[i].c,
             tab[i].err, tab[i].sel, tab[i].n, tab[i].stall);

    // Randomized ops against the reference model.
    for (int r = 0; r < 40; r++) begin
      logic [3:0]  opc;
      logic        ui;
      logic [31:0] a, b, c;
      opc = 4'($urandom_range(0, 15));
      ui  = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      c   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op(opc, ui, a, b, c, m_err(opc, ui, b, c),
             (opc <= 12) ? sel_tab[opc] : 0, m_cycles(opc),
             int'($urandom_range(0, 3)));
    end

    // Reset asserted in the 4th EXEC cycle of a DIV aborts it asynchronously.
    req_valid = 1'b1; req_opcode = 4'd4; req_use_imm = 1'b1;
    req_op1 = 32'd100; req_op2 = 32'd0; req_imm = 32'd7; rsp_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    chk("abort_pre_div", 64'(isDiv), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_strobes", 64'(sv), 64'd0);
    chk("abort_clr", 64'(clrResult), 64'd1);
    chk("abort_outs", 64'({busy, rsp_valid, aluSel, isImmediate, ldResult}), 64'd0);
    chk("abort_op1", 64'(op1_q), 64'd0);
    @(negedge clk);
    release_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end
    check_perf("abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
